// File: rtl/arb_mux_2to1_pkg.sv
// Shared constants and grant helper for the two-channel round-robin arbiter
// that feeds the registered 2:1 mux datapath.
package arb_mux_2to1_pkg;

    localparam int DW_DEFAULT = 8;

    localparam logic SEL_I0 = 1'b0;
    localparam logic SEL_I1 = 1'b1;

    // Channel 1 wins when it is alone, or on a tie when channel 0 was granted last.
    function automatic logic grant_sel(input logic v0, input logic v1, input logic last);
        return (v1 && !v0) || (v1 && v0 && (last == SEL_I0));
    endfunction

endpackage

// File: rtl/arb_mux_2to1_mux_21.sv
// Single-bit 2:1 mux gate; the leaf cell of the arbiter's data path.
module mux_21 (
    input  logic i0_bit,
    input  logic i1_bit,
    input  logic g,
    output logic y_bit
);

    assign y_bit = g ? i1_bit : i0_bit;

endmodule

// File: rtl/arb_mux_2to1.sv
// Registered round-robin arbiter for two valid/ready streams, steering a
// per-bit mux_21 datapath into a single output register with source tag s.
module arb_mux_2to1
    import arb_mux_2to1_pkg::*;
#(
    parameter int DW = DW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i0_valid,
    input  logic [DW-1:0] i0_data,
    output logic          i0_ready,
    input  logic          i1_valid,
    input  logic [DW-1:0] i1_data,
    output logic          i1_ready,
    output logic          y_valid,
    output logic [DW-1:0] y_data,
    input  logic          y_ready,
    output logic          s
);

    logic          out_free;
    logic          any_valid;
    logic          g;
    logic          last_grant;
    logic [DW-1:0] next_data;

    assign out_free  = !y_valid || y_ready;
    assign any_valid = i0_valid || i1_valid;
    assign g         = grant_sel(i0_valid, i1_valid, last_grant);

    // A channel is held off only when the other one is the current winner.
    assign i0_ready = out_free && !(i1_valid && (!i0_valid || (last_grant == SEL_I0)));
    assign i1_ready = out_free && !(i0_valid && (!i1_valid || (last_grant == SEL_I1)));

    generate
        for (genvar b = 0; b < DW; b++) begin : g_mux
            mux_21 u_mux (
                .i0_bit (i0_data[b]),
                .i1_bit (i1_data[b]),
                .g      (g),
                .y_bit  (next_data[b])
            );
        end
    endgenerate

    // last_grant resets to channel 1 so that the first tie favours channel 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_valid    <= 1'b0;
            y_data     <= '0;
            s          <= SEL_I0;
            last_grant <= SEL_I1;
        end else if (out_free) begin
            if (any_valid) begin
                y_valid    <= 1'b1;
                y_data     <= next_data;
                s          <= g;
                last_grant <= g;
            end else begin
                y_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_arb_mux_2to1.sv
// Scoreboard bench for arb_mux_2to1: a round-robin reference model predicts
// accepted words and readies; a monitor checks every word leaving on y.
module tb_arb_mux_2to1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i0_valid = 1'b0;
    logic [7:0] i0_data = 8'h00;
    logic       i0_ready;
    logic       i1_valid = 1'b0;
    logic [7:0] i1_data = 8'h00;
    logic       i1_ready;
    logic       y_valid;
    logic [7:0] y_data;
    logic       y_ready = 1'b0;
    logic       s;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model state: is the output slot occupied, who was served last.
    logic [8:0] exp_q[$];
    bit         model_occ = 1'b0;
    int         model_last = 1;

    arb_mux_2to1 #(.DW(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .i0_valid (i0_valid),
        .i0_data  (i0_data),
        .i0_ready (i0_ready),
        .i1_valid (i1_valid),
        .i1_data  (i1_data),
        .i1_ready (i1_ready),
        .y_valid  (y_valid),
        .y_data   (y_data),
        .y_ready  (y_ready),
        .s        (s)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [8:0] actual, input logic [8:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs at the falling edge and advance the model.
    task automatic applyStimulus(input bit r, input bit v0, input logic [7:0] d0,
                                 input bit v1, input logic [7:0] d1, input bit yr);
        bit out_free_m;
        bit anyv;
        int winner;
        @(negedge clk);
        rst = r;
        i0_valid = v0;
        i0_data = d0;
        i1_valid = v1;
        i1_data = d1;
        y_ready = yr;
        #1;
        out_free_m = !model_occ || yr;
        anyv = v0 || v1;
        if (v0 && v1) winner = 1 - model_last;
        else if (v1)  winner = 1;
        else          winner = 0;
        checkOutput("i0_ready", {8'h0, i0_ready}, {8'h0, out_free_m && (!anyv || winner == 0)});
        checkOutput("i1_ready", {8'h0, i1_ready}, {8'h0, out_free_m && (!anyv || winner == 1)});
        checkOutput("y_valid", {8'h0, y_valid}, {8'h0, model_occ});
        if (r) begin
            exp_q.delete();
            model_occ = 1'b0;
            model_last = 1;
        end else if (out_free_m && anyv) begin
            exp_q.push_back({winner[0], (winner == 1) ? d1 : d0});
            model_last = winner;
            model_occ = 1'b1;
        end else if (out_free_m) begin
            model_occ = 1'b0;
        end
    endtask

    // Monitor: every completed y handshake must match the oldest predicted word.
    always @(negedge clk) begin
        logic [8:0] exp_word;
        #2;
        if (!rst && y_valid && y_ready) begin
            if (exp_q.size() == 0) begin
                checkOutput("y_unexpected", {s, y_data}, 9'h1FF);
            end else begin
                exp_word = exp_q.pop_front();
                checkOutput("y_word", {s, y_data}, exp_word);
            end
        end
    end

    initial begin
        applyStimulus(1, 0, 8'h00, 0, 8'h00, 0);
        applyStimulus(1, 0, 8'h00, 0, 8'h00, 0);
        @(posedge clk);
        #1;
        checkOutput("rst_y_data", {1'b0, y_data}, 9'h000);
        checkOutput("rst_s", {8'h0, s}, 9'h000);
        applyStimulus(0, 0, 8'h00, 0, 8'h00, 0);

        applyStimulus(0, 0, 8'h00, 1, 8'hA5, 1);
        applyStimulus(0, 0, 8'h00, 0, 8'h00, 1);
        applyStimulus(0, 0, 8'h00, 0, 8'h00, 1);

        // Contention straight after reset, then backpressure on the first word.
        applyStimulus(1, 0, 8'h00, 0, 8'h00, 1);
        applyStimulus(0, 1, 8'h11, 1, 8'h22, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 8'h11, 1, 8'h22, 0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 8'h11, 1, 8'h22, 1);
        applyStimulus(0, 0, 8'h00, 0, 8'h00, 1);
        applyStimulus(0, 0, 8'h00, 0, 8'h00, 1);

        for (int i = 1; i <= 4; i++) applyStimulus(0, 1, 8'(i), 0, 8'h00, 1);
        applyStimulus(0, 1, 8'h33, 1, 8'h44, 1);
        applyStimulus(0, 1, 8'h55, 1, 8'h66, 1);

        // Reset while a word is held and both channels are competing.
        applyStimulus(1, 1, 8'h77, 1, 8'h88, 1);
        applyStimulus(0, 1, 8'h99, 1, 8'hAA, 1);
        applyStimulus(0, 0, 8'h00, 0, 8'h00, 1);
        applyStimulus(0, 0, 8'h00, 0, 8'h00, 1);

        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 49) == 0),
                          ($urandom_range(0, 9) < 6), 8'($urandom),
                          ($urandom_range(0, 9) < 6), 8'($urandom),
                          ($urandom_range(0, 9) < 7));
        end

        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 8'h00, 0, 8'h00, 1);
        checkOutput("drain_empty", 9'(exp_q.size()), 9'h000);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/arb_mux_2to1.md
Name: arb_mux_2to1

Overview:
- Registered two-channel round-robin arbiter placed directly upstream of the 2:1 mux datapath.
- Two valid/ready input streams (i0, i1) compete for one output stream (y).
- The block generates the select s that steers the mux, then registers the selected word.
- Data selection is built from per-bit mux_21 instances, so the existing mux gate is the datapath leaf.

Parameters:
- DW, 8, data width of i0_data, i1_data and y_data.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- i0_valid  input  1  channel 0 has a word.
- i0_data  input  DW  channel 0 word.
- i0_ready  output  1  channel 0 word accepted this cycle when i0_valid is also high.
- i1_valid  input  1  channel 1 has a word.
- i1_data  input  DW  channel 1 word.
- i1_ready  output  1  channel 1 word accepted this cycle when i1_valid is also high.
- y_valid  output  1  output register holds a word.
- y_data  output  DW  output word.
- y_ready  input  1  consumer accepts y this cycle.
- s  output  1  source channel of the word in y (0 = i0, 1 = i1); registered alongside y_data.

Behaviour:
- Single clock domain. Reset is synchronous, active-high and sampled on the rising edge of clk.
- Reset values:
  - y_valid = 0, y_data = 0, s = 0.
  - Internal last_grant = 1, so the first tie goes to i0.
- out_free = !y_valid | y_ready (combinational).
- Grant is combinational:
  - g = 1 if (i1_valid & !i0_valid) | (i1_valid & i0_valid & last_grant == 0).
  - Otherwise g = 0.
- Ready outputs:
  - i0_ready = out_free & !(i1_valid & (!i0_valid | last_grant == 0)).
  - i1_ready = out_free & !(i0_valid & (!i1_valid | last_grant == 1)).
  - At most one ready is asserted while both valids are high.
  - With no valids, both readies equal out_free.
- Transfer: when out_free and (i0_valid | i1_valid), on the next edge:
  - y_data <= g ? i1_data : i0_data.
  - y_valid <= 1, s <= g, last_grant <= g.
- Idle: when out_free and neither channel is valid, y_valid <= 0. y_data, s and last_grant hold.
- Stall: when y_valid & !y_ready, y_data, s and last_grant hold, and both readies are 0.
- Latency is 1 cycle, input accept to y_valid.
- Throughput is 1 word per cycle with no bubbles when y_ready is held at 1.
- Fairness: under continuous contention, grants alternate strictly 0,1,0,1...
- A single active requester is granted every cycle; last_grant is still updated.
- Simultaneous y_ready and a new accept: the old word leaves and the new word loads on the same edge.
- Reset mid-operation:
  - Any held word is discarded and y_valid drops the next cycle.
  - The next tie grants i0.
  - An input handshake completed in the reset cycle is discarded.

Decomposition:
- Shared package:
  - constants SEL_I0 = 1'b0 and SEL_I1 = 1'b1.
  - DW default of 8.
- Sub-module: mux_21, instantiated DW times in a generate loop (y_bit, i0_bit, i1_bit, g). It forms the combinational next-data value ahead of the output register.
- Grant logic and registers stay in arb_mux_2to1.

Test Plan:
1. Reset: hold rst=1 for 2 cycles with all inputs at 0 -> y_valid=0, y_data=8'h00, s=0; then i0_ready=1 and i1_ready=1 (out_free, no valids).
2. Single source: i1_valid=1 with i1_data=8'hA5 for 1 cycle, y_ready=1 -> next cycle y_valid=1, y_data=8'hA5, s=1; then y_valid=0.
3. Contention right after reset: i0_data=8'h11 and i1_data=8'h22, both valid continuously, y_ready=1 -> y_data sequence 11,22,11,22 with s = 0,1,0,1 and no bubbles.
4. Backpressure: y holds 8'h11 with y_ready=0 for 3 cycles -> y_data is stable and i0_ready=i1_ready=0; raise y_ready -> 8'h22 (s=1) appears the next cycle.
5. Back-to-back single source: i0 sends 01,02,03,04 on consecutive cycles -> y gives 01..04 on consecutive cycles with s=0; then both valid -> i1 is granted first (last_grant=0).
6. Reset mid-stream: assert rst while y_valid=1 and both channels valid -> next cycle y_valid=0; after release, the first tie grants i0 (s=0).
